// File: rtl/imuldiv_muldiv_arbiter_pkg.sv
// Shared definitions for the two-port mul/div arbiter: requester ids, function
// encodings of the shared iterative unit and result-width helpers.
package imuldiv_muldiv_arbiter_pkg;

   localparam int unsigned REQ_ID_W = 1;
   typedef logic [REQ_ID_W-1:0] req_id_t;

   localparam req_id_t REQ0 = 1'b0;
   localparam req_id_t REQ1 = 1'b1;

   localparam int unsigned FN_W       = 3;
   localparam int unsigned NBITS_DFLT = 32;

   typedef enum logic [FN_W-1:0] {
      FN_MUL  = 3'd0,
      FN_DIV  = 3'd1,
      FN_DIVU = 3'd2,
      FN_REM  = 3'd3,
      FN_REMU = 3'd4
   } muldiv_fn_e;

   function automatic int unsigned result_width(input int unsigned nbits);
      return 2 * nbits;
   endfunction

   function automatic req_id_t other_req(input req_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/imuldiv_muldiv_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each in-flight operation.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module imuldiv_muldiv_tag_fifo
   import imuldiv_muldiv_arbiter_pkg::*;
#(
   parameter  int unsigned p_depth = 4,
   localparam int unsigned AW      = $clog2(p_depth),
   localparam int unsigned CW      = AW + 1
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  req_id_t       tag_i,
   input  logic          pop_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o,
   output req_id_t       head_o
);

   localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

   logic [AW:0]                      wr_ptr_q, wr_ptr_d;
   logic [AW:0]                      rd_ptr_q, rd_ptr_d;
   logic [p_depth-1:0][REQ_ID_W-1:0] mem_q, mem_d;
   logic                             push_ok_s, pop_ok_s;

   // status flags and head tag
   always_comb begin
      full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      empty_o = (wr_ptr_q == rd_ptr_q);
      count_o = wr_ptr_q - rd_ptr_q;
      head_o  = mem_q[rd_ptr_q[AW-1:0]];
   end

   // next-state pointers and storage; overflow/underflow requests are ignored
   always_comb begin
      push_ok_s = push_i && !full_o;
      pop_ok_s  = pop_i && !empty_o;
      mem_d     = mem_q;
      if (push_ok_s) begin
         wr_ptr_d                   = wr_ptr_q + PTR_INC;
         mem_d[wr_ptr_q[AW-1:0]]    = tag_i;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_INC;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // state registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/imuldiv_muldiv_arbiter.sv
// Shares one iterative mul/div unit between two requesters: round-robin request
// arbitration, responses routed back in issue order via the tag FIFO.
module imuldiv_muldiv_arbiter
   import imuldiv_muldiv_arbiter_pkg::*;
#(
   parameter  int unsigned p_depth = 4,
   parameter  int unsigned p_nbits = NBITS_DFLT,
   localparam int unsigned CW      = $clog2(p_depth) + 1,
   localparam int unsigned RW      = 2 * p_nbits
)(
   input  logic               clk,
   input  logic               reset,

   input  logic [FN_W-1:0]    req0_msg_fn,
   input  logic [p_nbits-1:0] req0_msg_a,
   input  logic [p_nbits-1:0] req0_msg_b,
   input  logic               req0_val,
   output logic               req0_rdy,

   input  logic [FN_W-1:0]    req1_msg_fn,
   input  logic [p_nbits-1:0] req1_msg_a,
   input  logic [p_nbits-1:0] req1_msg_b,
   input  logic               req1_val,
   output logic               req1_rdy,

   output logic [RW-1:0]      resp0_msg_result,
   output logic               resp0_val,
   input  logic               resp0_rdy,

   output logic [RW-1:0]      resp1_msg_result,
   output logic               resp1_val,
   input  logic               resp1_rdy,

   output logic [FN_W-1:0]    muldivreq_msg_fn,
   output logic [p_nbits-1:0] muldivreq_msg_a,
   output logic [p_nbits-1:0] muldivreq_msg_b,
   output logic               muldivreq_val,
   input  logic               muldivreq_rdy,

   input  logic [RW-1:0]      muldivresp_msg_result,
   input  logic               muldivresp_val,
   output logic               muldivresp_rdy,

   output logic [CW-1:0]      inflight_count,
   output logic               err_orphan
);

   req_id_t prio_q, prio_d;
   logic    err_orphan_q, err_orphan_d;
   req_id_t grant_s;
   logic    any_val_s, accept_s;
   logic    push_s, pop_s;
   logic    full_s, empty_s;
   req_id_t head_s;
   logic    resp_live_s, head_rdy_s;

   imuldiv_muldiv_tag_fifo #(
      .p_depth (p_depth)
   ) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s),
      .tag_i   (grant_s),
      .pop_i   (pop_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (inflight_count),
      .head_o  (head_s)
   );

   // grant: the lone valid requester, or the favoured one under contention
   always_comb begin
      grant_s = REQ0;
      if (req0_val && req1_val) begin
         grant_s = prio_q;
      end else if (req1_val) begin
         grant_s = REQ1;
      end else begin
         grant_s = REQ0;
      end
   end

   // request path; with nobody requesting both ports simply mirror unit readiness
   always_comb begin
      any_val_s     = req0_val || req1_val;
      accept_s      = muldivreq_rdy && !full_s;
      muldivreq_val = any_val_s && !full_s;
      req0_rdy      = accept_s && !(any_val_s && (grant_s == REQ1));
      req1_rdy      = accept_s && !(any_val_s && (grant_s == REQ0));
      if (grant_s == REQ1) begin
         muldivreq_msg_fn = req1_msg_fn;
         muldivreq_msg_a  = req1_msg_a;
         muldivreq_msg_b  = req1_msg_b;
      end else begin
         muldivreq_msg_fn = req0_msg_fn;
         muldivreq_msg_a  = req0_msg_a;
         muldivreq_msg_b  = req0_msg_b;
      end
      push_s = muldivreq_val && muldivreq_rdy;
   end

   // response demux steered by the oldest outstanding tag
   always_comb begin
      resp_live_s      = muldivresp_val && !empty_s;
      resp0_val        = resp_live_s && (head_s == REQ0);
      resp1_val        = resp_live_s && (head_s == REQ1);
      resp0_msg_result = muldivresp_msg_result;
      resp1_msg_result = muldivresp_msg_result;
      if (head_s == REQ1) begin
         head_rdy_s = resp1_rdy;
      end else begin
         head_rdy_s = resp0_rdy;
      end
      muldivresp_rdy = !empty_s && head_rdy_s;
      pop_s          = muldivresp_val && muldivresp_rdy;
   end

   // round-robin pointer hands priority to the other side after each issue
   always_comb begin
      if (push_s) begin
         prio_d = other_req(grant_s);
      end else begin
         prio_d = prio_q;
      end
      err_orphan_d = err_orphan_q || (muldivresp_val && empty_s);
      err_orphan   = err_orphan_q;
   end

   // state registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         prio_q       <= REQ0;
         err_orphan_q <= 1'b0;
      end else begin
         prio_q       <= prio_d;
         err_orphan_q <= err_orphan_d;
      end
   end

endmodule

// File: tb/tb_imuldiv_muldiv_arbiter.sv
// Self-checking bench for imuldiv_muldiv_arbiter: combinational vector table,
// directed multi-cycle sequences and a randomized run against a queue-based model.
module tb_imuldiv_muldiv_arbiter;
   import imuldiv_muldiv_arbiter_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        reset;
   logic [2:0]  req0_msg_fn, req1_msg_fn, muldivreq_msg_fn;
   logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b, muldivreq_msg_a, muldivreq_msg_b;
   logic        req0_val, req0_rdy, req1_val, req1_rdy;
   logic [63:0] resp0_msg_result, resp1_msg_result, muldivresp_msg_result;
   logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic        muldivreq_val, muldivreq_rdy, muldivresp_val, muldivresp_rdy;
   logic [2:0]  inflight_count;
   logic        err_orphan;

   imuldiv_muldiv_arbiter #(.p_depth(DEPTH), .p_nbits(32)) dut (
      .clk(clk), .reset(reset),
      .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
      .req0_val(req0_val), .req0_rdy(req0_rdy),
      .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
      .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
      .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
      .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
      .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
      .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
      .muldivresp_rdy(muldivresp_rdy),
      .inflight_count(inflight_count), .err_orphan(err_orphan)
   );

   int vectors = 0;
   int miscompares = 0;

   // stimulus state per requester and knobs of the stub shared unit
   logic        r_val [2];
   logic [2:0]  r_fn  [2];
   logic [31:0] r_a   [2];
   logic [31:0] r_b   [2];
   logic        u_req_rdy, u_resp_en, force_orphan;
   logic        resp_rdy_tb [2];

   // reference model: issue-order tags, per-port expected results, stub unit queue
   int          tagq[$];
   logic [63:0] expq0[$], expq1[$], unit_q[$];
   int          grant_log[$];
   int          resp_port_log[$];
   logic [63:0] resp_data_log[$];
   int          prio_m;
   bit          err_m;
   int          issued [2];

   logic [2:0]  snap_count;
   logic        snap_rdy0, snap_rdy1;

   typedef struct {
      logic r0v, r1v, mrdy;
      logic e_r0rdy, e_r1rdy, e_mval;
      int   e_sel;
   } cvec_t;
   cvec_t tbl [8];

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] lo;
      case (fn)
         3'd0: begin lo = a * b; return {32'h0, lo}; end
         3'd2: return {a % b, a / b};
         default: return {a, b};
      endcase
   endfunction

   task automatic issue(input int i, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      r_val[i] = 1'b1; r_fn[i] = fn; r_a[i] = a; r_b[i] = b;
   endtask

   task automatic issue_rand(input int i);
      logic [2:0] fn;
      fn = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd2;
      issue(i, fn, $urandom, (fn == 3'd2) ? 32'($urandom_range(1, 1000)) : $urandom);
      issued[i]++;
   endtask

   // one clock: drive, compare every output against the model, then advance the model
   task automatic step();
      bit any, full, empty, mrv, rfire, pfire;
      int win, h;
      logic [63:0] exp_r, act_r;
      @(negedge clk);
      reset = 1'b1;
      req0_val = r_val[0]; req0_msg_fn = r_fn[0]; req0_msg_a = r_a[0]; req0_msg_b = r_b[0];
      req1_val = r_val[1]; req1_msg_fn = r_fn[1]; req1_msg_a = r_a[1]; req1_msg_b = r_b[1];
      mrv = force_orphan || (u_resp_en && unit_q.size() != 0);
      muldivresp_val = mrv;
      muldivresp_msg_result = (unit_q.size() != 0) ? unit_q[0] : 64'h0;
      muldivreq_rdy = u_req_rdy;
      resp0_rdy = resp_rdy_tb[0]; resp1_rdy = resp_rdy_tb[1];
      #1;
      snap_count = inflight_count; snap_rdy0 = req0_rdy; snap_rdy1 = req1_rdy;
      any   = r_val[0] || r_val[1];
      full  = (tagq.size() == DEPTH);
      empty = (tagq.size() == 0);
      win   = (r_val[0] && r_val[1]) ? prio_m : (r_val[1] ? 1 : 0);
      check64("muldivreq_val", 64'(muldivreq_val), 64'(any && !full));
      if (any && !full) begin
         check64("muldivreq_fn", 64'(muldivreq_msg_fn), 64'(r_fn[win]));
         check64("muldivreq_a", 64'(muldivreq_msg_a), 64'(r_a[win]));
         check64("muldivreq_b", 64'(muldivreq_msg_b), 64'(r_b[win]));
      end
      check64("req0_rdy", 64'(req0_rdy), 64'(u_req_rdy && !full && !(any && win == 1)));
      check64("req1_rdy", 64'(req1_rdy), 64'(u_req_rdy && !full && !(any && win == 0)));
      h = empty ? 0 : tagq[0];
      check64("resp0_val", 64'(resp0_val), 64'(mrv && !empty && h == 0));
      check64("resp1_val", 64'(resp1_val), 64'(mrv && !empty && h == 1));
      check64("muldivresp_rdy", 64'(muldivresp_rdy), 64'(!empty && resp_rdy_tb[h]));
      check64("inflight_count", 64'(inflight_count), 64'(tagq.size()));
      check64("err_orphan", 64'(err_orphan), 64'(err_m));
      rfire = any && !full && u_req_rdy;
      pfire = mrv && !empty && resp_rdy_tb[h];
      if (pfire) begin
         exp_r = (h == 0) ? expq0[0] : expq1[0];
         act_r = (h == 0) ? resp0_msg_result : resp1_msg_result;
         check64("resp_result", act_r, exp_r);
         resp_port_log.push_back(h);
         resp_data_log.push_back(act_r);
         void'(tagq.pop_front());
         void'(unit_q.pop_front());
         if (h == 0) void'(expq0.pop_front()); else void'(expq1.pop_front());
      end
      if (mrv && empty) err_m = 1'b1;
      if (rfire) begin
         exp_r = ref_result(r_fn[win], r_a[win], r_b[win]);
         tagq.push_back(win);
         unit_q.push_back(exp_r);
         if (win == 0) expq0.push_back(exp_r); else expq1.push_back(exp_r);
         grant_log.push_back(win);
         r_val[win] = 1'b0;
         prio_m = 1 - win;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      r_val[0] = 1'b0; r_val[1] = 1'b0; force_orphan = 1'b0;
      req0_val = 1'b0; req1_val = 1'b0; muldivresp_val = 1'b0; muldivreq_rdy = 1'b1;
      tagq.delete(); expq0.delete(); expq1.delete(); unit_q.delete();
      grant_log.delete(); resp_port_log.delete(); resp_data_log.delete();
      prio_m = 0; err_m = 1'b0; issued[0] = 0; issued[1] = 0;
      @(negedge clk);
      #1;
      check64("rst_count", 64'(inflight_count), 64'h0);
      check64("rst_err", 64'(err_orphan), 64'h0);
      check64("rst_resp0_val", 64'(resp0_val), 64'h0);
      check64("rst_resp1_val", 64'(resp1_val), 64'h0);
      check64("rst_mreq_val", 64'(muldivreq_val), 64'h0);
      check64("rst_mresp_rdy", 64'(muldivresp_rdy), 64'h0);
   endtask

   task automatic run_until_idle(input int budget, input string name);
      int n = 0;
      while ((r_val[0] || r_val[1] || tagq.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check64(name, 64'(tagq.size()) + 64'(r_val[0]) + 64'(r_val[1]), 64'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
      tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};

      reset = 1'b0; r_val[0] = 1'b0; r_val[1] = 1'b0;
      r_fn[0] = 3'd0; r_fn[1] = 3'd0; r_a[0] = 32'h0; r_a[1] = 32'h0; r_b[0] = 32'h0; r_b[1] = 32'h0;
      req0_msg_fn = 3'd0; req1_msg_fn = 3'd0; req0_msg_b = 32'h0; req1_msg_b = 32'h0;
      req0_msg_a = 32'h0; req1_msg_a = 32'h0; muldivresp_msg_result = 64'h0;
      u_req_rdy = 1'b1; u_resp_en = 1'b1; force_orphan = 1'b0;
      resp_rdy_tb[0] = 1'b1; resp_rdy_tb[1] = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      do_reset();

      // combinational table from the reset state; inputs are withdrawn before each edge
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         reset = 1'b1;
         req0_val = tbl[i].r0v; req1_val = tbl[i].r1v; muldivreq_rdy = tbl[i].mrdy;
         req0_msg_a = 32'hA0A0_0000 + 32'(i); req1_msg_a = 32'hB1B1_0000 + 32'(i);
         muldivresp_val = 1'b0;
         #1;
         check64("tbl_req0_rdy", 64'(req0_rdy), 64'(tbl[i].e_r0rdy));
         check64("tbl_req1_rdy", 64'(req1_rdy), 64'(tbl[i].e_r1rdy));
         check64("tbl_mreq_val", 64'(muldivreq_val), 64'(tbl[i].e_mval));
         check64("tbl_mresp_rdy", 64'(muldivresp_rdy), 64'h0);
         if (tbl[i].e_mval)
            check64("tbl_mreq_a", 64'(muldivreq_msg_a),
                    (tbl[i].e_sel == 1) ? 64'(32'hB1B1_0000 + 32'(i)) : 64'(32'hA0A0_0000 + 32'(i)));
         #1;
         req0_val = 1'b0; req1_val = 1'b0;
      end

      // 1: lone requester 0
      issue(0, 3'd0, 32'h0000_0008, 32'h0000_0003);
      run_until_idle(20, "t1_drain");
      check64("t1_nresp", 64'(resp_port_log.size()), 64'h1);
      if (resp_port_log.size() == 1) begin
         check64("t1_port", 64'(resp_port_log[0]), 64'h0);
         check64("t1_data", resp_data_log[0], 64'h0000_0000_0000_0018);
      end

      // 2: contention straight after reset
      do_reset();
      issue(0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(1, 3'd2, 32'h0000_000B, 32'h0000_0003);
      run_until_idle(20, "t2_drain");
      check64("t2_nresp", 64'(resp_port_log.size()), 64'h2);
      if (resp_port_log.size() == 2) begin
         check64("t2_grant0", 64'(grant_log[0]), 64'h0);
         check64("t2_port0", 64'(resp_port_log[0]), 64'h0);
         check64("t2_data0", resp_data_log[0], 64'h0000_0000_0000_0001);
         check64("t2_port1", 64'(resp_port_log[1]), 64'h1);
         check64("t2_data1", resp_data_log[1], 64'h0000_0002_0000_0003);
      end

      // 3: both ports streaming alternate strictly
      do_reset();
      n = 0;
      while ((issued[0] < 8 || issued[1] < 8 || r_val[0] || r_val[1]) && n < 200) begin
         for (int i = 0; i < 2; i++) if (!r_val[i] && issued[i] < 8) issue_rand(i);
         step();
         n++;
      end
      run_until_idle(50, "t3_drain");
      check64("t3_ngrant", 64'(grant_log.size()), 64'd16);
      for (int k = 0; k < grant_log.size(); k++) check64("t3_grant", 64'(grant_log[k]), 64'(k % 2));

      // 4: head-of-line blocking on port 0
      do_reset();
      resp_rdy_tb[0] = 1'b0;
      issue(0, 3'd0, 32'h0000_0005, 32'h0000_0007);
      issue(1, 3'd2, 32'h0000_0064, 32'h0000_0009);
      for (int k = 0; k < 50; k++) step();
      check64("t4_blocked", 64'(resp_port_log.size()), 64'h0);
      resp_rdy_tb[0] = 1'b1;
      run_until_idle(20, "t4_drain");
      check64("t4_nresp", 64'(resp_port_log.size()), 64'h2);
      if (resp_port_log.size() == 2) begin
         check64("t4_order0", 64'(resp_port_log[0]), 64'h0);
         check64("t4_order1", 64'(resp_port_log[1]), 64'h1);
      end

      // 5: unit never answers -> FIFO fills and stalls both ports
      do_reset();
      u_resp_en = 1'b0;
      n = 0;
      while (tagq.size() < DEPTH && n < 30) begin
         for (int i = 0; i < 2; i++) if (!r_val[i]) issue_rand(i);
         step();
         n++;
      end
      for (int i = 0; i < 2; i++) if (!r_val[i]) issue_rand(i);
      step();
      check64("t5_full_count", 64'(snap_count), 64'd4);
      check64("t5_full_rdy0", 64'(snap_rdy0), 64'h0);
      check64("t5_full_rdy1", 64'(snap_rdy1), 64'h0);
      u_resp_en = 1'b1;
      step();
      u_resp_en = 1'b0;
      step();
      check64("t5_count3", 64'(snap_count), 64'd3);
      check64("t5_rdy_back", 64'(snap_rdy0 || snap_rdy1), 64'h1);
      u_resp_en = 1'b1;
      r_val[0] = 1'b0; r_val[1] = 1'b0;
      run_until_idle(30, "t5_drain");

      // 6: orphan response, then reset with tags in flight
      do_reset();
      force_orphan = 1'b1;
      step();
      force_orphan = 1'b0;
      step();
      check64("t6_err_sticky", 64'(err_orphan), 64'h1);
      u_resp_en = 1'b0;
      issue(0, 3'd0, 32'h0000_0002, 32'h0000_0002);
      step();
      issue(1, 3'd0, 32'h0000_0003, 32'h0000_0003);
      step();
      check64("t6_inflight", 64'(snap_count), 64'h1);
      do_reset();
      u_resp_en = 1'b1;
      issue(0, 3'd0, 32'h0000_0004, 32'h0000_0004);
      issue(1, 3'd0, 32'h0000_0006, 32'h0000_0006);
      step();
      check64("t6_prio_reset", 64'(grant_log.size() > 0 ? grant_log[0] : 9), 64'h0);
      run_until_idle(20, "t6_drain");

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) if (!r_val[i] && $urandom_range(0, 2) == 0) issue_rand(i);
         u_req_rdy      = ($urandom_range(0, 3) != 0);
         u_resp_en      = ($urandom_range(0, 2) != 0);
         resp_rdy_tb[0] = ($urandom_range(0, 3) != 0);
         resp_rdy_tb[1] = ($urandom_range(0, 3) != 0);
         step();
      end
      u_req_rdy = 1'b1; u_resp_en = 1'b1; resp_rdy_tb[0] = 1'b1; resp_rdy_tb[1] = 1'b1;
      run_until_idle(100, "rand_drain");
      check64("rand_exp0_empty", 64'(expq0.size()), 64'h0);
      check64("rand_exp1_empty", 64'(expq1.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
